// File: rtl/xtea_enc_arbiter.sv
// Two-requester round-robin front end for a single XTEA encipher engine.
// The engine is restarted through its reset; the result returns with a one-cycle ack.
module xtea_enc_arbiter #(
    parameter int unsigned RST_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned CNT_W          = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [31:0]  req0_data1,
    input  logic [31:0]  req0_data2,
    input  logic [127:0] req0_key,
    output logic         req0_ack,
    input  logic         req1_valid,
    input  logic [31:0]  req1_data1,
    input  logic [31:0]  req1_data2,
    input  logic [127:0] req1_key,
    output logic         req1_ack,
    output logic         res_valid,
    output logic         res_id,
    output logic         res_err,
    output logic [31:0]  res_data1,
    output logic [31:0]  res_data2,
    output logic         busy,
    output logic         eng_reset,
    output logic [31:0]  eng_data1,
    output logic [31:0]  eng_data2,
    output logic [127:0] eng_key,
    input  logic [31:0]  eng_out1,
    input  logic [31:0]  eng_out2,
    input  logic         eng_done
);

    localparam int unsigned      RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST     = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [RST_W-1:0] rst_cnt;
    logic [CNT_W-1:0] wd_cnt;
    logic             grant_id;
    logic             last_grant;
    logic             req_any;
    logic             pick;
    logic             finish_d;
    logic [31:0]      op_data1;
    logic [31:0]      op_data2;
    logic [127:0]     op_key;

    // Round-robin pick: on a tie the requester that was not served last wins.
    assign req_any  = req0_valid | req1_valid;
    assign pick     = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    assign finish_d = (state_d == S_CAPTURE) || (state_d == S_ERR);

    assign eng_data1 = op_data1;
    assign eng_data2 = op_data2;
    assign eng_key   = op_key;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (req_any) begin
                    state_d = S_RST;
                end
            end
            S_RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A done seen on the final watchdog cycle still counts as success.
                if (eng_done) begin
                    state_d = S_CAPTURE;
                end else if (wd_cnt == WD_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_CAPTURE: state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs, all decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            rst_cnt    <= '0;
            wd_cnt     <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            op_data1   <= '0;
            op_data2   <= '0;
            op_key     <= '0;
            res_data1  <= '0;
            res_data2  <= '0;
            res_id     <= 1'b0;
            res_err    <= 1'b0;
            res_valid  <= 1'b0;
            req0_ack   <= 1'b0;
            req1_ack   <= 1'b0;
            busy       <= 1'b0;
            eng_reset  <= 1'b1;
        end else begin
            eng_reset <= (state_d != S_RUN);
            busy      <= (state_d != S_IDLE);
            res_valid <= finish_d;
            req0_ack  <= finish_d & ~grant_id;
            req1_ack  <= finish_d & grant_id;

            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        grant_id <= pick;
                        rst_cnt  <= '0;
                        op_data1 <= pick ? req1_data1 : req0_data1;
                        op_data2 <= pick ? req1_data2 : req0_data2;
                        op_key   <= pick ? req1_key   : req0_key;
                    end
                end
                S_RST: begin
                    rst_cnt <= rst_cnt + RST_W'(1);
                    wd_cnt  <= '0;
                end
                S_RUN: begin
                    wd_cnt <= wd_cnt + CNT_W'(1);
                    if (eng_done) begin
                        res_data1 <= eng_out1;
                        res_data2 <= eng_out2;
                        res_err   <= 1'b0;
                        res_id    <= grant_id;
                    end else if (wd_cnt == WD_LAST) begin
                        res_data1 <= '0;
                        res_data2 <= '0;
                        res_err   <= 1'b1;
                        res_id    <= grant_id;
                    end
                end
                S_CAPTURE: last_grant <= grant_id;
                S_ERR:     last_grant <= grant_id;
                default:   ;
            endcase
        end
    end

endmodule

// File: doc/xtea_enc_arbiter.md
Name: xtea_enc_arbiter

Overview:
- Controller that shares one XTEA encipher engine between two requesters.
- The engine has no start input. It restarts only through its reset, then runs its 32-round loop, then raises all_done and holds it.
- This block arbitrates round-robin between the requesters, latches the winner's operands, and pulses the engine reset.
- It then waits for all_done (with a watchdog), captures the ciphertext and returns it to the granted requester with a one-cycle ack.

Parameters:
- RST_CYCLES, 2: number of cycles eng_reset is held high after operands are latched (minimum 1).
- TIMEOUT_CYCLES, 1023: maximum cycles in RUN before the operation is aborted with an error.
- CNT_W, 10: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending (level)
- req0_data1  in  32  requester 0 plaintext word 1
- req0_data2  in  32  requester 0 plaintext word 2
- req0_key  in  128  requester 0 key
- req0_ack  out  1  one-cycle pulse; result for requester 0 on res_* this cycle
- req1_valid, req1_data1, req1_data2, req1_key, req1_ack: same as requester 0
- res_valid  out  1  one-cycle pulse; res_* are valid this cycle
- res_id  out  1  requester index the result belongs to
- res_err  out  1  1 = watchdog timeout; result data forced to 0
- res_data1  out  32  ciphertext word 1 (held until next res_valid)
- res_data2  out  32  ciphertext word 2 (held until next res_valid)
- busy  out  1  high in any state other than IDLE
- eng_reset  out  1  drives the engine reset
- eng_data1  out  32  engine data_in1, from the operand register
- eng_data2  out  32  engine data_in2, from the operand register
- eng_key  out  128  engine key_in, from the operand register
- eng_out1  in  32  engine data_out1
- eng_out2  in  32  engine data_out2
- eng_done  in  1  engine all_done

Behaviour:
- Reset values:
  - state=IDLE, eng_reset=1.
  - Operand registers 0; res_data1/res_data2/res_id/res_err 0.
  - res_valid, req0_ack, req1_ack, busy all 0.
  - last_grant=1, so requester 0 wins the first tie.
- IDLE:
  - eng_reset=1.
  - Neither valid: stay in IDLE.
  - One valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - On grant, the same edge latches that requester's data1/data2/key into the operand registers, records the grant index, clears the RST counter, and moves to RST.
- RST:
  - eng_reset=1 for exactly RST_CYCLES cycles, then go to RUN and clear the watchdog.
  - eng_done is ignored here; it is stale from the previous operation.
- RUN:
  - eng_reset=0; the watchdog increments every cycle.
  - eng_done sampled 1: go to CAPTURE; eng_out1/eng_out2 are registered into res_data1/res_data2 on that same edge.
  - Else, watchdog == TIMEOUT_CYCLES-1: go to ERR.
  - If done and timeout coincide on the same cycle, done wins.
- CAPTURE (1 cycle):
  - res_valid=1, res_err=0, res_id=grant index; the granted reqN_ack=1.
  - last_grant updated to the grant index; next state IDLE.
- ERR (1 cycle):
  - res_valid=1, res_err=1, res_data1=res_data2=0, res_id=grant index; the granted reqN_ack=1.
  - last_grant updated; next state IDLE; eng_reset returns to 1.
- Outputs:
  - eng_data1, eng_data2 and eng_key come only from the operand registers. They are stable from RST entry until the return to IDLE, independent of requester inputs.
  - Acks and res_valid are registered state decodes; they are never combinational from inputs.
- Handshake:
  - A requester holds valid and operands until its ack.
  - Operands are captured at grant. A requester that drops valid after grant still receives its ack and result.
  - A requester that is still valid in the cycle after its ack is treated as a new request. It is arbitrated normally and loses a tie to the other requester.
- Latency: the grant edge is cycle 0; RST occupies cycles 1..RST_CYCLES; RUN lasts until eng_done is seen; res_valid comes 1 cycle after eng_done is sampled. Minimum back-to-back spacing is IDLE→IDLE in RST_CYCLES+3+engine-run cycles.
- Reset mid-operation: the next edge returns to IDLE with reset values. No ack or res_valid is issued for the aborted operation, and eng_reset=1 immediately.
- No arithmetic is performed on data; the counters saturate at no point in legal operation.

Test Plan:
- req0 only, data 0x00000000/0x00000000, key 0 → req0_ack=1, res_valid=1, res_id=0, res_err=0, res_data1=0xDEE9D4D8, res_data2=0xF7131ED9. eng_reset is high exactly RST_CYCLES cycles after the grant.
- req0 and req1 asserted in the same cycle after reset → req0 served first, then req1; res_id sequence 0,1. With both held continuously, grants alternate 0,1,0,1.
- req1 changes its operands while req0 is being processed → eng_data1/eng_data2/eng_key stay at req0's latched values until req0_ack.
- Engine model that never raises eng_done, TIMEOUT_CYCLES=16 → after 16 RUN cycles: res_valid=1, res_err=1, res_data=0, ack to the granted requester, then IDLE.
- Stale eng_done=1 held from a previous op → not accepted during RST; the result is captured only after a fresh done in RUN.
- reset asserted mid-RUN → next cycle state IDLE, busy=0, eng_reset=1, no ack or res_valid. A subsequent req0 completes normally.
